// File: rtl/audio_pkg.sv
// Shared audio-path types and defaults for the tone generator, envelope stage and PWM DACs.
package audio_pkg;

    localparam int N_DEF            = 8;
    localparam int ENV_W_DEF        = 8;
    localparam int ATTACK_STEP_DEF  = 8;
    localparam int DECAY_STEP_DEF   = 2;
    localparam int SUSTAIN_LVL_DEF  = 160;
    localparam int RELEASE_STEP_DEF = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } env_state_t;

endpackage

// File: rtl/env_scale.sv
// Unsigned N x ENV_W multiply keeping the upper N bits, so full-scale level is ~unity gain.
module env_scale #(
    parameter int N     = 8,
    parameter int ENV_W = 8
) (
    input  logic [N-1:0]     i_sample,
    input  logic [ENV_W-1:0] i_level,
    output logic [N-1:0]     o_scaled
);

    logic [N+ENV_W-1:0] w_prod;

    assign w_prod   = (N+ENV_W)'(i_sample) * (N+ENV_W)'(i_level);
    assign o_scaled = N'(w_prod >> ENV_W);

endmodule

// File: rtl/note_envelope.sv
// Linear ADSR envelope applied to both half-wave samples, advanced only on fs_clk ticks.
module note_envelope
    import audio_pkg::*;
#(
    parameter int N            = N_DEF,
    parameter int ENV_W        = ENV_W_DEF,
    parameter int ATTACK_STEP  = ATTACK_STEP_DEF,
    parameter int DECAY_STEP   = DECAY_STEP_DEF,
    parameter int SUSTAIN_LVL  = SUSTAIN_LVL_DEF,
    parameter int RELEASE_STEP = RELEASE_STEP_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fs_clk,
    input  logic             note_on,
    input  logic             note_off,
    input  logic [N-1:0]     pos_in,
    input  logic [N-1:0]     neg_in,
    output logic [N-1:0]     pos_out,
    output logic [N-1:0]     neg_out,
    output logic [ENV_W-1:0] env_level,
    output logic             active,
    output env_state_t       o_state
);

    localparam logic [ENV_W:0] C_FULL = (ENV_W+1)'((1 << ENV_W) - 1);
    localparam logic [ENV_W:0] C_ATK  = (ENV_W+1)'(ATTACK_STEP);
    localparam logic [ENV_W:0] C_DEC  = (ENV_W+1)'(DECAY_STEP);
    localparam logic [ENV_W:0] C_SUS  = (ENV_W+1)'(SUSTAIN_LVL);
    localparam logic [ENV_W:0] C_REL  = (ENV_W+1)'(RELEASE_STEP);

    env_state_t       r_state;
    env_state_t       w_state_nxt;
    env_state_t       w_step_state;
    logic [ENV_W-1:0] r_level;
    logic [ENV_W-1:0] w_level_nxt;
    logic [N-1:0]     r_pos;
    logic [N-1:0]     r_neg;
    logic             r_active;
    logic             r_on_pend;
    logic             r_off_pend;
    logic             w_on_any;
    logic             w_off_any;
    logic [ENV_W:0]   w_lvl_ext;
    logic [ENV_W:0]   w_sum;
    logic [ENV_W:0]   w_dec_diff;
    logic [ENV_W:0]   w_rel_diff;
    logic [N-1:0]     w_pos_scaled;
    logic [N-1:0]     w_neg_scaled;

    // note_on/note_off are single-cycle strobes with no back-pressure: a strobe
    // landing in a tick cycle is folded straight into that tick, otherwise it
    // is held in a pending flag until the next tick consumes it.
    assign w_on_any   = r_on_pend | note_on;
    assign w_off_any  = r_off_pend | note_off;

    assign w_lvl_ext  = {1'b0, r_level};
    assign w_sum      = w_lvl_ext + C_ATK;
    assign w_dec_diff = w_lvl_ext - C_DEC;
    assign w_rel_diff = w_lvl_ext - C_REL;

    // A strobe picks the state whose step is applied on this very tick, so a
    // retrigger at level L yields L+ATTACK_STEP immediately.
    always_comb begin
        w_step_state = r_state;
        if (w_on_any) begin
            w_step_state = ATTACK;
        end else if (w_off_any && (r_state == ATTACK || r_state == DECAY ||
                                   r_state == SUSTAIN)) begin
            w_step_state = RELEASE;
        end
    end

    always_comb begin
        w_state_nxt = w_step_state;
        w_level_nxt = r_level;
        case (w_step_state)
            IDLE: begin
                w_level_nxt = '0;
            end
            ATTACK: begin
                if (w_sum >= C_FULL) begin
                    w_level_nxt = C_FULL[ENV_W-1:0];
                    w_state_nxt = DECAY;
                end else begin
                    w_level_nxt = w_sum[ENV_W-1:0];
                end
            end
            DECAY: begin
                if (w_lvl_ext <= C_SUS + C_DEC) begin
                    w_level_nxt = C_SUS[ENV_W-1:0];
                    w_state_nxt = SUSTAIN;
                end else begin
                    w_level_nxt = w_dec_diff[ENV_W-1:0];
                end
            end
            SUSTAIN: begin
                w_level_nxt = r_level;
            end
            RELEASE: begin
                if (w_lvl_ext <= C_REL) begin
                    w_level_nxt = '0;
                    w_state_nxt = IDLE;
                end else begin
                    w_level_nxt = w_rel_diff[ENV_W-1:0];
                end
            end
            default: begin
                w_level_nxt = '0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    env_scale #(.N(N), .ENV_W(ENV_W)) u_scale_pos (
        .i_sample (pos_in),
        .i_level  (r_level),
        .o_scaled (w_pos_scaled)
    );

    env_scale #(.N(N), .ENV_W(ENV_W)) u_scale_neg (
        .i_sample (neg_in),
        .i_level  (r_level),
        .o_scaled (w_neg_scaled)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_level    <= '0;
            r_pos      <= '0;
            r_neg      <= '0;
            r_active   <= 1'b0;
            r_on_pend  <= 1'b0;
            r_off_pend <= 1'b0;
        end else if (fs_clk) begin
            r_state    <= w_state_nxt;
            r_level    <= w_level_nxt;
            r_pos      <= w_pos_scaled;
            r_neg      <= w_neg_scaled;
            r_active   <= (w_state_nxt != IDLE);
            r_on_pend  <= 1'b0;
            r_off_pend <= 1'b0;
        end else begin
            if (note_on) begin
                r_on_pend <= 1'b1;
            end
            if (note_off) begin
                r_off_pend <= 1'b1;
            end
        end
    end

    assign pos_out   = r_pos;
    assign neg_out   = r_neg;
    assign env_level = r_level;
    assign active    = r_active;
    assign o_state   = r_state;

endmodule

// File: tb/tb_note_envelope.sv
// Bench for note_envelope: hand-computed vector table, directed envelope walk, randomized run vs. model.
module tb_note_envelope;
    import audio_pkg::*;

    logic       clk;
    logic       reset;
    logic       fs_clk;
    logic       note_on;
    logic       note_off;
    logic [7:0] pos_in;
    logic [7:0] neg_in;
    logic [7:0] pos_out;
    logic [7:0] neg_out;
    logic [7:0] env_level;
    logic       active;
    env_state_t o_state;

    int n_checks;
    int n_fail;

    // behavioural reference state
    int         m_level;
    int         m_pos;
    int         m_neg;
    bit         m_on;
    bit         m_off;
    env_state_t m_state;

    typedef struct {
        bit         tk;
        bit         on;
        bit         off;
        logic [7:0] p;
        logic [7:0] n;
        int         e_level;
        int         e_pos;
        int         e_neg;
        bit         e_active;
    } vec_t;

    vec_t vt[8];

    note_envelope dut (
        .clk       (clk),
        .reset     (reset),
        .fs_clk    (fs_clk),
        .note_on   (note_on),
        .note_off  (note_off),
        .pos_in    (pos_in),
        .neg_in    (neg_in),
        .pos_out   (pos_out),
        .neg_out   (neg_out),
        .env_level (env_level),
        .active    (active),
        .o_state   (o_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit rst, input bit tk, input bit on, input bit off,
                              input logic [7:0] p, input logic [7:0] n);
        bit         pon;
        bit         poff;
        env_state_t st;
        if (rst) begin
            m_level = 0; m_pos = 0; m_neg = 0; m_on = 0; m_off = 0; m_state = IDLE;
            return;
        end
        if (!tk) begin
            m_on  = m_on | on;
            m_off = m_off | off;
            return;
        end
        pon  = m_on | on;
        poff = m_off | off;
        m_on = 0;
        m_off = 0;
        m_pos = (int'(p) * m_level) / 256;
        m_neg = (int'(n) * m_level) / 256;
        st = m_state;
        if (pon) st = ATTACK;
        else if (poff && st inside {ATTACK, DECAY, SUSTAIN}) st = RELEASE;
        m_state = st;
        if (st == ATTACK) begin
            m_level = (m_level + 8 > 255) ? 255 : m_level + 8;
            if (m_level == 255) m_state = DECAY;
        end else if (st == DECAY) begin
            m_level = (m_level - 2 < 160) ? 160 : m_level - 2;
            if (m_level == 160) m_state = SUSTAIN;
        end else if (st == RELEASE) begin
            m_level = (m_level - 4 < 0) ? 0 : m_level - 4;
            if (m_level == 0) m_state = IDLE;
        end
    endtask

    task automatic cycle(input bit rst, input bit tk, input bit on, input bit off,
                         input logic [7:0] p, input logic [7:0] n);
        reset = rst; fs_clk = tk; note_on = on; note_off = off; pos_in = p; neg_in = n;
        model_step(rst, tk, on, off, p, n);
        @(posedge clk);
        #1;
        chk("model_level", env_level, m_level);
        chk("model_pos", pos_out, m_pos);
        chk("model_neg", neg_out, m_neg);
        chk("model_active", active, (m_state != IDLE));
        chk("model_state", o_state, m_state);
    endtask

    task automatic tick(input logic [7:0] p, input logic [7:0] n);
        cycle(0, 1, 0, 0, p, n);
        cycle(0, 0, 0, 0, p, n);
    endtask

    task automatic do_reset();
        cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b1; fs_clk = 1'b0; note_on = 1'b0; note_off = 1'b0;
        pos_in = '0; neg_in = '0;
        model_step(1, 0, 0, 0, 0, 0);

        vt[0] = '{0, 1, 0, 8'd0,   8'd0,   0,  0,  0,  0};
        vt[1] = '{1, 0, 0, 8'd200, 8'd10,  8,  0,  0,  1};
        vt[2] = '{1, 0, 0, 8'd200, 8'd10,  16, 6,  0,  1};
        vt[3] = '{0, 0, 0, 8'd77,  8'd77,  16, 6,  0,  1};
        vt[4] = '{1, 0, 0, 8'd100, 8'd50,  24, 6,  3,  1};
        vt[5] = '{1, 0, 0, 8'd255, 8'd128, 32, 23, 12, 1};
        vt[6] = '{0, 0, 1, 8'd0,   8'd0,   32, 23, 12, 1};
        vt[7] = '{1, 0, 0, 8'd255, 8'd255, 28, 31, 31, 1};

        // reset state
        do_reset();
        chk("rst_level", env_level, 0);
        chk("rst_pos", pos_out, 0);
        chk("rst_neg", neg_out, 0);
        chk("rst_active", active, 0);
        chk("rst_state", o_state, IDLE);

        // vector table
        for (int i = 0; i < 8; i++) begin
            cycle(0, vt[i].tk, vt[i].on, vt[i].off, vt[i].p, vt[i].n);
            chk($sformatf("vec%0d_level", i), env_level, vt[i].e_level);
            chk($sformatf("vec%0d_pos", i), pos_out, vt[i].e_pos);
            chk($sformatf("vec%0d_neg", i), neg_out, vt[i].e_neg);
            chk($sformatf("vec%0d_active", i), active, vt[i].e_active);
        end
        chk("vec_release_state", o_state, RELEASE);

        // attack walk: 40 ticks at pos_in=200
        do_reset();
        cycle(0, 0, 1, 0, 8'd200, 8'd200);
        for (int k = 1; k <= 40; k++) begin
            tick(8'd200, 8'd200);
            if (k == 31) chk("atk_tick31", env_level, 248);
            if (k == 32) begin
                chk("atk_tick32_sat", env_level, 255);
                chk("atk_tick32_pos", pos_out, (200 * 248) >> 8);
            end
            if (k == 33) begin
                chk("dec_tick33", env_level, 253);
                chk("dec_tick33_pos", pos_out, (200 * 255) >> 8);
                chk("dec_tick33_state", o_state, DECAY);
            end
        end
        // remaining decay ticks: 8 already done, 48 total reach 160
        for (int j = 9; j <= 48; j++) begin
            tick(8'd200, 8'd200);
            if (j == 47) chk("dec_47", env_level, 161);
            if (j == 48) begin
                chk("dec_48_sustain_lvl", env_level, 160);
                chk("dec_48_state", o_state, SUSTAIN);
            end
        end
        for (int j = 0; j < 100; j++) tick(8'd255, 8'($urandom_range(0, 255)));
        chk("sus_level", env_level, 160);
        chk("sus_pos255", pos_out, 159);

        // release from sustain
        cycle(0, 0, 0, 1, 8'd255, 8'd255);
        for (int j = 1; j <= 40; j++) begin
            tick(8'd255, 8'd255);
            if (j == 39) chk("rel_39", env_level, 4);
        end
        chk("rel_done_level", env_level, 0);
        chk("rel_done_state", o_state, IDLE);
        chk("rel_done_active", active, 0);
        for (int j = 0; j < 5; j++) tick(8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)));
        chk("idle_pos", pos_out, 0);
        chk("idle_neg", neg_out, 0);

        // retrigger from release at level 100
        cycle(0, 0, 1, 0, 8'd90, 8'd90);
        for (int i = 0; i < 200 && o_state != SUSTAIN; i++) tick(8'd90, 8'd90);
        chk("reach_sustain", o_state, SUSTAIN);
        cycle(0, 0, 0, 1, 8'd90, 8'd90);
        for (int j = 0; j < 15; j++) tick(8'd90, 8'd90);
        chk("rel_at_100", env_level, 100);
        cycle(0, 0, 1, 0, 8'd90, 8'd90);
        tick(8'd90, 8'd90);
        chk("retrig_108", env_level, 108);
        chk("retrig_state", o_state, ATTACK);

        // off then on between the same two ticks: retrigger wins, off discarded
        cycle(0, 0, 0, 1, 8'd90, 8'd90);
        cycle(0, 0, 1, 0, 8'd90, 8'd90);
        tick(8'd90, 8'd90);
        chk("both_level", env_level, 116);
        chk("both_state", o_state, ATTACK);
        tick(8'd90, 8'd90);
        chk("off_cleared_level", env_level, 124);
        chk("off_cleared_state", o_state, ATTACK);

        // note_on coincident with a tick, from RELEASE
        cycle(0, 0, 0, 1, 8'd90, 8'd90);
        tick(8'd90, 8'd90);
        chk("rel_from_124", env_level, 120);
        cycle(0, 1, 1, 0, 8'd90, 8'd90);
        chk("same_cycle_on_level", env_level, 128);
        chk("same_cycle_on_state", o_state, ATTACK);
        tick(8'd90, 8'd90);
        chk("same_cycle_on_next", env_level, 136);

        // reset mid-decay with stale strobes pending
        for (int i = 0; i < 200 && !(o_state == DECAY && env_level <= 201); i++) tick(8'd220, 8'd30);
        chk("reach_decay_200", (o_state == DECAY && env_level <= 201), 1);
        cycle(0, 0, 1, 0, 8'd220, 8'd30);
        cycle(0, 0, 0, 1, 8'd220, 8'd30);
        cycle(1, 0, 0, 0, 8'd220, 8'd30);
        chk("mid_rst_level", env_level, 0);
        chk("mid_rst_pos", pos_out, 0);
        chk("mid_rst_neg", neg_out, 0);
        chk("mid_rst_state", o_state, IDLE);
        chk("mid_rst_active", active, 0);
        cycle(0, 0, 0, 0, 8'd220, 8'd30);
        for (int j = 0; j < 4; j++) tick(8'd220, 8'd30);
        chk("stale_level", env_level, 0);
        chk("stale_state", o_state, IDLE);

        // randomized run against the model
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 499) == 0),
                  ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 29) == 0),
                  8'($urandom_range(0, 255)),
                  8'($urandom_range(0, 255)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
